// File: rtl/cfg_col_loader.sv
// rtl/cfg_col_loader.sv - per-column configuration deserializer feeding MY tile shift chains.
// Optional CFG_COL_PARITY_EN adds a trailing parity bit that gates the commit pulse.
`timescale 1ns/1ps
module cfg_col_loader #(
    parameter int TILE_CFG_SIZE = 256,
    parameter int MY            = 4,
    parameter int COL_ID        = 0
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic [3:0]    col_sel,
    input  logic          cfg_in_start,
    input  logic          cfg_bit_in,
    input  logic          cfg_bit_in_valid,
    output logic          cfg_bit_o,
    output logic [MY-1:0] cfg_shift_o,
    output logic          cfg_commit_o,
    output logic          cfg_busy_o,
    output logic          cfg_done_o,
    output logic          cfg_ovf_o,
    output logic          cfg_err_o
);

    localparam int BW = $clog2(TILE_CFG_SIZE);
    localparam int TW = (MY > 1) ? $clog2(MY) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_PARITY = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] bit_cnt;
    logic [TW-1:0] tile_cnt;
    logic          sel;
    logic          start;
    logic          bit_v;
    logic          last_bit;
    logic          accept;
    logic          ovf_hit;
    logic          commit_q;

    assign sel      = (col_sel == 4'(COL_ID));
    assign start    = sel & cfg_in_start;
    // A valid that coincides with a start is dropped.
    assign bit_v    = sel & cfg_bit_in_valid & ~cfg_in_start;
    assign last_bit = (bit_cnt == BW'(TILE_CFG_SIZE - 1)) && (tile_cnt == TW'(MY - 1));

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_LOAD;
        end else begin
            case (state)
                S_IDLE:   state_nxt = S_IDLE;
                S_LOAD: begin
                    if (accept && last_bit) begin
`ifdef CFG_COL_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_COMMIT;
`endif
                    end
                end
                S_PARITY: if (bit_v) state_nxt = S_COMMIT;
                S_COMMIT: state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        accept      = bit_v && (state == S_LOAD);
        ovf_hit     = bit_v && ((state == S_IDLE) || (state == S_COMMIT));
        cfg_busy_o  = (state != S_IDLE);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            bit_cnt     <= '0;
            tile_cnt    <= '0;
            cfg_bit_o   <= 1'b0;
            cfg_shift_o <= '0;
            commit_q    <= 1'b0;
            cfg_done_o  <= 1'b0;
            cfg_ovf_o   <= 1'b0;
        end else begin
            cfg_shift_o <= '0;
            commit_q    <= 1'b0;
            if (start) begin
                bit_cnt    <= '0;
                tile_cnt   <= '0;
                cfg_done_o <= 1'b0;
                cfg_ovf_o  <= 1'b0;
            end else begin
                // commit_q trails the COMMIT state by one edge so it never overlaps the last shift.
                commit_q <= (state == S_COMMIT);
                if (commit_q) begin
                    cfg_done_o <= 1'b1;
                end
                if (ovf_hit) begin
                    cfg_ovf_o <= 1'b1;
                end
                if (accept) begin
                    cfg_bit_o   <= cfg_bit_in;
                    cfg_shift_o <= MY'(1) << tile_cnt;
                    if (bit_cnt == BW'(TILE_CFG_SIZE - 1)) begin
                        bit_cnt  <= '0;
                        tile_cnt <= tile_cnt + TW'(1);
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
            end
        end
    end

`ifdef CFG_COL_PARITY_EN
    logic par_acc;
    logic err_q;
    logic par_take;

    assign par_take = bit_v && (state == S_PARITY);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            par_acc <= 1'b0;
            err_q   <= 1'b0;
        end else if (start) begin
            par_acc <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                par_acc <= par_acc ^ cfg_bit_in;
            end
            if (par_take && (par_acc != cfg_bit_in)) begin
                err_q <= 1'b1;
            end
        end
    end

    // The COMMIT state is still visited on error so done is reported; only the pulse is masked.
    assign cfg_err_o    = err_q;
    assign cfg_commit_o = commit_q & ~err_q;
`else
    assign cfg_err_o    = 1'b0;
    assign cfg_commit_o = commit_q;
`endif

endmodule

// File: tb/tb_cfg_col_loader.sv
// tb/tb_cfg_col_loader.sv - randomized self-checking bench for cfg_col_loader against a stream-position model.
`timescale 1ns/1ps
module tb_cfg_col_loader;

    localparam int TCS    = 8;
    localparam int MY     = 4;
    localparam int COL_ID = 2;
    localparam int N      = TCS * MY;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    col_sel;
    logic          cfg_in_start;
    logic          cfg_bit_in;
    logic          cfg_bit_in_valid;
    logic          cfg_bit_o;
    logic [MY-1:0] cfg_shift_o;
    logic          cfg_commit_o;
    logic          cfg_busy_o;
    logic          cfg_done_o;
    logic          cfg_ovf_o;
    logic          cfg_err_o;

    cfg_col_loader #(
        .TILE_CFG_SIZE (TCS),
        .MY            (MY),
        .COL_ID        (COL_ID)
    ) dut (
        .wb_clk_i         (clk),
        .wb_rst_ni        (rst_n),
        .col_sel          (col_sel),
        .cfg_in_start     (cfg_in_start),
        .cfg_bit_in       (cfg_bit_in),
        .cfg_bit_in_valid (cfg_bit_in_valid),
        .cfg_bit_o        (cfg_bit_o),
        .cfg_shift_o      (cfg_shift_o),
        .cfg_commit_o     (cfg_commit_o),
        .cfg_busy_o       (cfg_busy_o),
        .cfg_done_o       (cfg_done_o),
        .cfg_ovf_o        (cfg_ovf_o),
        .cfg_err_o        (cfg_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observed activity, sampled on the falling edge.
    int obs_shift[$];
    int obs_bit[$];
    int obs_cyc[$];
    int obs_commit[$];
    bit nonzero_seen;

    always @(negedge clk) begin
        if (cfg_shift_o != '0) begin
            obs_shift.push_back(int'(cfg_shift_o));
            obs_bit.push_back(int'(cfg_bit_o));
            obs_cyc.push_back(cyc);
        end
        if (cfg_commit_o) obs_commit.push_back(cyc);
        if (cfg_bit_o || (|cfg_shift_o) || cfg_commit_o || cfg_busy_o ||
            cfg_done_o || cfg_ovf_o || cfg_err_o) nonzero_seen = 1'b1;
    end

    // Reference model: position in the column stream and coarse phase.
    int exp_tile[$];
    int exp_bit[$];
    int exp_cyc[$];
    int exp_commit[$];
    int m_pos;
    int m_phase;   // 0 not loading, 1 data bits, 2 waiting for parity
    bit m_par;
    bit m_done;
    bit m_ovf;
    bit m_err;

    function automatic void model_clear();
        m_pos = 0; m_phase = 0; m_par = 0; m_done = 0; m_ovf = 0; m_err = 0;
        exp_tile.delete(); exp_bit.delete(); exp_cyc.delete(); exp_commit.delete();
        obs_shift.delete(); obs_bit.delete(); obs_cyc.delete(); obs_commit.delete();
    endfunction

    function automatic void model_step(input logic [3:0] cs, input bit st, input bit b,
                                       input bit v, input int dcyc);
        if (cs != 4'(COL_ID)) return;
        if (st) begin
            m_pos = 0; m_phase = 1; m_par = 0; m_done = 0; m_ovf = 0; m_err = 0;
            return;
        end
        if (!v) return;
        if (m_phase == 1) begin
            exp_tile.push_back(m_pos / TCS);
            exp_bit.push_back(int'(b));
            exp_cyc.push_back(dcyc + 1);
            m_par = m_par ^ b;
            m_pos++;
            if (m_pos == N) begin
`ifdef CFG_COL_PARITY_EN
                m_phase = 2;
`else
                m_phase = 0;
                exp_commit.push_back(dcyc + 2);
                m_done = 1;
`endif
            end
        end else if (m_phase == 2) begin
            m_phase = 0;
            m_done  = 1;
            if (b != m_par) m_err = 1;
            else exp_commit.push_back(dcyc + 2);
        end else begin
            m_ovf = 1;
        end
    endfunction

    task automatic drive(input logic [3:0] cs, input bit st, input bit b, input bit v);
        col_sel = cs; cfg_in_start = st; cfg_bit_in = b; cfg_bit_in_valid = v;
        model_step(cs, st, b, v, cyc);
        @(posedge clk);
        #1;
        cfg_in_start = 1'b0;
        cfg_bit_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(col_sel, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_bits(input logic [3:0] cs, input int n);
        for (int i = 0; i < n; i++) drive(cs, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    endtask

    // Parity builds need the trailer bit; default builds send nothing.
    task automatic send_tail();
`ifdef CFG_COL_PARITY_EN
        drive(4'(COL_ID), 1'b0, m_par, 1'b1);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cfg_in_start = 1'b0; cfg_bit_in_valid = 1'b0; cfg_bit_in = 1'b0; col_sel = 4'(COL_ID);
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        rst_n = 1'b1;
    endtask

    task automatic verify(input string tag);
        int n;
        check({tag, "/n_shift"}, obs_shift.size(), exp_tile.size());
        n = (obs_shift.size() < exp_tile.size()) ? obs_shift.size() : exp_tile.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "/shift"}, obs_shift[i], 32'(1) << exp_tile[i]);
            check({tag, "/bit"}, obs_bit[i], exp_bit[i]);
            check({tag, "/lat"}, obs_cyc[i], exp_cyc[i]);
        end
        check({tag, "/n_commit"}, obs_commit.size(), exp_commit.size());
        n = (obs_commit.size() < exp_commit.size()) ? obs_commit.size() : exp_commit.size();
        for (int i = 0; i < n; i++) check({tag, "/commit_cyc"}, obs_commit[i], exp_commit[i]);
        check({tag, "/done"}, cfg_done_o, m_done);
        check({tag, "/ovf"}, cfg_ovf_o, m_ovf);
        check({tag, "/err"}, cfg_err_o, m_err);
        check({tag, "/busy"}, cfg_busy_o, (m_phase != 0));
        exp_tile.delete(); exp_bit.delete(); exp_cyc.delete(); exp_commit.delete();
        obs_shift.delete(); obs_bit.delete(); obs_cyc.delete(); obs_commit.delete();
    endtask

    initial begin
        rst_n = 1'b1;
        col_sel = 4'(COL_ID); cfg_in_start = 1'b0; cfg_bit_in = 1'b0; cfg_bit_in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst/bit", cfg_bit_o, 0);
        check("rst/shift", cfg_shift_o, 0);
        check("rst/commit", cfg_commit_o, 0);
        check("rst/busy", cfg_busy_o, 0);
        check("rst/done", cfg_done_o, 0);
        check("rst/ovf", cfg_ovf_o, 0);
        check("rst/err", cfg_err_o, 0);
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        rst_n = 1'b1;
        idle(2);
        verify("post_rst");

        // Full back-to-back column load.
        drive(4'(COL_ID), 1'b1, 1'b0, 1'b0);
        check("start/busy", cfg_busy_o, 1);
        send_bits(4'(COL_ID), N);
        send_tail();
        idle(4);
        verify("full");

        // Another column's traffic must leave this instance untouched.
        do_reset();
        nonzero_seen = 1'b0;
        drive(4'd3, 1'b1, 1'b0, 1'b0);
        send_bits(4'd3, N);
        drive(4'd3, 1'b0, 1'b1, 1'b1);
        idle(4);
        check("other/quiet", nonzero_seen, 0);
        verify("other");

        // Pause mid-load while another column is addressed.
        do_reset();
        drive(4'(COL_ID), 1'b1, 1'b0, 1'b0);
        send_bits(4'(COL_ID), 12);
        send_bits(4'd1, 5);
        check("pause/busy", cfg_busy_o, 1);
        send_bits(4'(COL_ID), 20);
        send_tail();
        idle(4);
        verify("pause");

        // Restart aborts a partial load; start-coincident valid is dropped.
        do_reset();
        drive(4'(COL_ID), 1'b1, 1'b0, 1'b0);
        send_bits(4'(COL_ID), 10);
        drive(4'(COL_ID), 1'b1, 1'b1, 1'b1);
        send_bits(4'(COL_ID), N);
        send_tail();
        idle(4);
        verify("restart");

        // Overflow after done, then cleared by a fresh start.
        drive(4'(COL_ID), 1'b0, 1'b1, 1'b1);
        idle(2);
        verify("ovf");
        drive(4'(COL_ID), 1'b1, 1'b0, 1'b0);
        check("ovf_clr/ovf", cfg_ovf_o, 0);
        check("ovf_clr/done", cfg_done_o, 0);
        send_bits(4'(COL_ID), N);
        send_tail();
        drive(4'(COL_ID), 1'b0, 1'b1, 1'b1);
        idle(4);
        verify("reload");

        // Reset mid-load discards the partial column with no commit.
        do_reset();
        drive(4'(COL_ID), 1'b1, 1'b0, 1'b0);
        send_bits(4'(COL_ID), 15);
        idle(1);
        verify("partial");
        do_reset();
        idle(4);
        verify("partial_rst");

`ifdef CFG_COL_PARITY_EN
        // Wrong parity: done but no commit pulse.
        do_reset();
        drive(4'(COL_ID), 1'b1, 1'b0, 1'b0);
        begin
            bit b;
            bit x;
            x = 1'b0;
            for (int i = 0; i < N; i++) begin
                b = (i == N - 1) ? ~x : 1'($urandom_range(0, 1));
                x = x ^ b;
                drive(4'(COL_ID), 1'b0, b, 1'b1);
            end
        end
        check("par_bad/busy", cfg_busy_o, 1);
        drive(4'(COL_ID), 1'b0, 1'b0, 1'b1);
        idle(4);
        check("par_bad/err_model", cfg_err_o, 1);
        verify("par_bad");

        drive(4'(COL_ID), 1'b1, 1'b0, 1'b0);
        check("par_good/err_clr", cfg_err_o, 0);
        send_bits(4'(COL_ID), N);
        send_tail();
        idle(4);
        verify("par_good");
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
